// File: rtl/data_mem_stage.sv
// Multi-cycle load/store stage behind the EX ALU; stalls the CPU until each access completes.
// Define DMEM_BYTE_ACCESS_EN for byte/half access with extension; otherwise every access is a word.
module data_mem_stage #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [31:0]     r_rdata;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_write;
  logic            w_any;
  logic            w_illegal;
  logic            w_misaligned;
  logic            w_bad_size;
  logic            w_accept;
  logic            w_access;
  logic            w_stall;
  logic            w_done;
  logic            w_err;
  logic [31:0]     w_word;
  logic [31:0]     w_load;
  logic [31:0]     w_merge;

`ifdef DMEM_BYTE_ACCESS_EN
  logic [1:0]      r_lane;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  always_comb begin
    w_misaligned = 1'b0;
    w_bad_size   = 1'b0;
    case (size_i)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = addr_i[0];
      2'b10:   w_misaligned = |addr_i[1:0];
      default: w_bad_size   = 1'b1;
    endcase
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{size_i, unsigned_i};
  assign w_misaligned = |addr_i[1:0];
  assign w_bad_size   = 1'b0;
`endif

  // Requests are masked during reset so nothing stalls or errors while rst_i is high.
  assign w_any     = (mem_read_i | mem_write_i) & ~rst_i;
  assign w_illegal = (mem_read_i & mem_write_i) | w_bad_size | w_misaligned
                   | (addr_i >= ADDR_LIMIT);
  assign w_accept  = (r_state == IDLE) & w_any & ~w_illegal;
  assign w_access  = (r_state == BUSY) & (r_cnt == '0) & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= CW'(LATENCY - 1);
      else if (r_state == BUSY && r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          if (w_illegal) begin
            w_err = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_next  = BUSY;
          end
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == '0) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_idx   <= addr_i[AW+1:2];
      r_wdata <= wdata_i;
      r_write <= mem_write_i;
`ifdef DMEM_BYTE_ACCESS_EN
      r_lane     <= addr_i[1:0];
      r_size     <= size_i;
      r_unsigned <= unsigned_i;
`endif
    end
  end

  assign w_word = r_mem[r_idx];

`ifdef DMEM_BYTE_ACCESS_EN
  always_comb begin
    w_byte  = w_word[{r_lane, 3'b000} +: 8];
    w_half  = w_word[{r_lane[1], 4'b0000} +: 16];
    w_load  = w_word;
    w_merge = w_word;
    case (r_size)
      2'b00: begin
        w_load = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
        w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load = {{16{w_half[15] & ~r_unsigned}}, w_half};
        w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: begin
        w_load  = w_word;
        w_merge = r_wdata;
      end
    endcase
  end
`else
  assign w_load  = w_word;
  assign w_merge = r_wdata;
`endif

  // Array has no reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (w_access && r_write)
      r_mem[r_idx] <= w_merge;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_rdata <= '0;
    else if (w_access && !r_write)
      r_rdata <= w_load;
  end

  assign rdata_o = r_rdata;
  assign stall_o = w_stall;
  assign done_o  = w_done;
  assign err_o   = w_err;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed self-checking bench for data_mem_stage; byte/half vectors run only when
// DMEM_BYTE_ACCESS_EN is defined, word-only behaviour is checked otherwise.
module tb_data_mem_stage;

  localparam int LATENCY = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] lastRdata;

  always #5 clk_i = ~clk_i;

  data_mem_stage #(.DEPTH_WORDS(128), .LATENCY(LATENCY)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .mem_read_i (mem_read_i),
    .mem_write_i(mem_write_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    mem_read_i  = rd;
    mem_write_i = wr;
    size_i      = size;
    unsigned_i  = uns;
    addr_i      = addr;
    wdata_i     = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
  endtask

  // One legal access: stall through c0..cLATENCY, done in the following cycle.
  task automatic access(input string tag, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic chk, input logic [31:0] expData);
    applyStimulus(!wr, wr, size, uns, addr, wdata);
    #1;
    for (int c = 0; c <= LATENCY; c++) begin
      checkOutput($sformatf("%s_stall_c%0d", tag, c), {31'b0, stall_o}, 32'd1);
      step();
    end
    checkOutput({tag, "_done"}, {31'b0, done_o}, 32'd1);
    checkOutput({tag, "_stallInDone"}, {31'b0, stall_o}, 32'd0);
    if (chk) checkOutput({tag, "_rdata"}, rdata_o, expData);
    step();
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput({tag, "_idleAfter"}, {31'b0, done_o}, 32'd0);
  endtask

  // One rejected request: err pulse, no stall, rdata untouched.
  task automatic errCase(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expRdata);
    applyStimulus(rd, wr, size, uns, addr, wdata);
    #1;
    checkOutput({tag, "_err"}, {31'b0, err_o}, 32'd1);
    checkOutput({tag, "_stall"}, {31'b0, stall_o}, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput({tag, "_errClear"}, {31'b0, err_o}, 32'd0);
    checkOutput({tag, "_noDone"}, {31'b0, done_o}, 32'd0);
    checkOutput({tag, "_rdataKept"}, rdata_o, expRdata);
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    #3;
    checkOutput("reset_rdata", rdata_o, 32'h0);
    checkOutput("reset_stall", {31'b0, stall_o}, 32'd0);
    checkOutput("reset_done", {31'b0, done_o}, 32'd0);
    checkOutput("reset_err", {31'b0, err_o}, 32'd0);
    step();
    step();
    rst_i = 1'b0;
    step();
    checkOutput("postReset_stall", {31'b0, stall_o}, 32'd0);

    access("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    access("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
    access("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 1'b0, 32'h0);

`ifdef DMEM_BYTE_ACCESS_EN
    access("lbS23", 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b1, 32'hFFFFFF80);
    access("lbU23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b1, 32'h00000080);
    access("lhS20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b1, 32'h00007F01);
    access("lhS22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b1, 32'hFFFF80FF);
    access("lbU21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b1, 32'h0000007F);
    access("sw20b", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0);
    access("sb21",  1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA, 1'b0, 32'h0);
    access("lw20a", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h1122AA44);
    access("sh22",  1'b1, 2'b01, 1'b0, 32'h22, 32'h12345566, 1'b0, 32'h0);
    access("lw20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h5566AA44);
    lastRdata = 32'h5566AA44;
`else
    access("lSizeIgnored", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b1, 32'h80FF7F01);
    errCase("lbMisaligned23", 1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h80FF7F01);
    access("sSizeIgnored", 1'b1, 2'b00, 1'b0, 32'h20, 32'h1122AA44, 1'b0, 32'h0);
    access("lw20full", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h1122AA44);
    lastRdata = 32'h1122AA44;
`endif

    access("sw00", 1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFEF00D, 1'b0, 32'h0);
    errCase("lwMis02",   1'b1, 1'b0, 2'b10, 1'b0, 32'h02,  32'h0,        lastRdata);
    errCase("shMis01",   1'b0, 1'b1, 2'b01, 1'b0, 32'h01,  32'h0000FFFF, lastRdata);
    errCase("lwRange200", 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0,       lastRdata);
    errCase("rdAndWr",   1'b1, 1'b1, 2'b10, 1'b0, 32'h10,  32'h0,        lastRdata);
`ifdef DMEM_BYTE_ACCESS_EN
    errCase("size11",    1'b1, 1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        lastRdata);
`endif
    access("lw00kept", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b1, 32'hCAFEF00D);
    access("lw10kept", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);

    access("sw1FC", 1'b1, 2'b10, 1'b0, 32'h1FC, 32'hA5A5A5A5, 1'b0, 32'h0);
    access("lw1FC", 1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, 1'b1, 32'hA5A5A5A5);

    access("sw30zero", 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678);
    #1;
    checkOutput("rstMid_c0stall", {31'b0, stall_o}, 32'd1);
    step();
    checkOutput("rstMid_busyStall", {31'b0, stall_o}, 32'd1);
    checkOutput("rstMid_rdataBefore", rdata_o, 32'hA5A5A5A5);
    rst_i = 1'b1;
    #1;
    checkOutput("rstMid_stall", {31'b0, stall_o}, 32'd0);
    checkOutput("rstMid_rdata", rdata_o, 32'h0);
    checkOutput("rstMid_done", {31'b0, done_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    step();
    rst_i = 1'b0;
    step();
    checkOutput("rstMid_idleStall", {31'b0, stall_o}, 32'd0);
    access("lw30afterRst", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
